mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/datapath_cache_if.sv | 36 +++
 rtl/mem_resp_ram.sv | 35 +++
 rtl/mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared CPU datatypes; adds the memory-responder FSM state and
//            latched request type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HIT  = 2'd2,
        DONE = 2'd3
    } mem_resp_state_t;

    typedef enum logic [1:0] {
        REQ_INSTR = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/datapath_cache_if.sv
// ============================================================================
// Module   : datapath_cache_if
// Brief    : Datapath <-> memory handshake bundle (datapath and cache views).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface datapath_cache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;
    logic  halt;
    logic  flushed;

    modport dp (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  ihit, imemload, dhit, dmemload, flushed
    );

    modport cache (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output ihit, imemload, dhit, dmemload, flushed
    );

endinterface

`default_nettype wire

// File: rtl/mem_resp_ram.sv
// ============================================================================
// Module   : mem_resp_ram
// Brief    : Word store with one synchronous write port and one combinational
//            read port; contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_resp_ram
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  word_t            i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output word_t            o_rdata
);

    word_t r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Fixed-latency memory model answering instruction/data requests.
//            Optional hit/wait statistics under MEM_RESP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                   CLK,
    input  logic                   nRST,
    datapath_cache_if.cache        dcif,
    input  logic                   init_wen,
    input  word_t                  init_addr,
    input  word_t                  init_data,
    output word_t                  ihit_count,
    output word_t                  dhit_count,
    output word_t                  wait_count
);

    localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_lat_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         c_zero_lat = (LATENCY == 0);

    mem_resp_state_t r_state;
    mem_req_t        r_req;
    logic [3:0]      r_cnt;
    logic            r_ihit;
    logic            r_dhit;
    logic            r_flushed;
    logic            r_halt_pend;

    logic               w_req_valid;
    mem_req_t           w_req_sel;
    logic               w_req_held;
    logic               w_halt_now;
    logic               w_hit_wr;
    logic               w_we;
    logic [c_idx_w-1:0] w_iidx;
    logic [c_idx_w-1:0] w_didx;
    logic [c_idx_w-1:0] w_init_idx;
    logic [c_idx_w-1:0] w_raddr;
    logic [c_idx_w-1:0] w_waddr;
    word_t              w_wdata;
    word_t              w_rdata;
    logic               w_unused;

    // Upper address bits and byte offset are dropped, so addresses wrap.
    assign w_iidx     = dcif.imemaddr[c_idx_w+1:2];
    assign w_didx     = dcif.dmemaddr[c_idx_w+1:2];
    assign w_init_idx = init_addr[c_idx_w+1:2];
    assign w_unused   = ^{dcif.imemaddr[31:c_idx_w+2], dcif.imemaddr[1:0],
                          dcif.dmemaddr[31:c_idx_w+2], dcif.dmemaddr[1:0],
                          init_addr[31:c_idx_w+2], init_addr[1:0]};

    always_comb begin
        w_req_valid = dcif.dmemREN | dcif.dmemWEN | dcif.imemREN;
        if (dcif.dmemWEN) begin
            w_req_sel = REQ_WRITE;
        end else if (dcif.dmemREN) begin
            w_req_sel = REQ_READ;
        end else begin
            w_req_sel = REQ_INSTR;
        end
        case (r_req)
            REQ_INSTR: w_req_held = dcif.imemREN;
            REQ_READ:  w_req_held = dcif.dmemREN;
            default:   w_req_held = dcif.dmemWEN;
        endcase
        w_halt_now = dcif.halt | r_halt_pend;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_req       <= REQ_INSTR;
            r_cnt       <= '0;
            r_ihit      <= 1'b0;
            r_dhit      <= 1'b0;
            r_flushed   <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (dcif.halt) begin
                        r_state   <= DONE;
                        r_flushed <= 1'b1;
                    end else if (w_req_valid) begin
                        r_req <= w_req_sel;
                        if (c_zero_lat) begin
                            r_state <= HIT;
                            r_ihit  <= (w_req_sel == REQ_INSTR);
                            r_dhit  <= (w_req_sel != REQ_INSTR);
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= c_lat_load;
                        end
                    end
                end
                WAIT: begin
                    if (dcif.halt) begin
                        r_halt_pend <= 1'b1;
                    end
                    // A dropped request aborts; a pending halt still retires to DONE.
                    if (!w_req_held) begin
                        r_state     <= w_halt_now ? DONE : IDLE;
                        r_flushed   <= w_halt_now;
                        r_halt_pend <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= HIT;
                        r_ihit  <= (r_req == REQ_INSTR);
                        r_dhit  <= (r_req != REQ_INSTR);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HIT: begin
                    r_state     <= w_halt_now ? DONE : IDLE;
                    r_flushed   <= w_halt_now;
                    r_halt_pend <= 1'b0;
                end
                default: begin
                    r_flushed <= 1'b1;
                end
            endcase
        end
    end

    // Write hit owns the single write port; preload only gets it otherwise.
    assign w_hit_wr = r_dhit && (r_req == REQ_WRITE) && nRST;
    assign w_we     = w_hit_wr | init_wen;
    assign w_waddr  = w_hit_wr ? w_didx : w_init_idx;
    assign w_wdata  = w_hit_wr ? dcif.dmemstore : init_data;
    assign w_raddr  = (r_req == REQ_INSTR) ? w_iidx : w_didx;

    mem_resp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_idx_w)
    ) u_ram (
        .clk     (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign dcif.ihit     = r_ihit;
    assign dcif.dhit     = r_dhit;
    assign dcif.flushed  = r_flushed;
    assign dcif.imemload = r_ihit ? w_rdata : '0;
    assign dcif.dmemload = (r_dhit && (r_req == REQ_READ)) ? w_rdata : '0;

`ifdef MEM_RESP_STATS_EN
    word_t r_ihit_cnt;
    word_t r_dhit_cnt;
    word_t r_wait_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ihit_cnt <= '0;
            r_dhit_cnt <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (r_ihit && (r_ihit_cnt != '1)) begin
                r_ihit_cnt <= r_ihit_cnt + 32'd1;
            end
            if (r_dhit && (r_dhit_cnt != '1)) begin
                r_dhit_cnt <= r_dhit_cnt + 32'd1;
            end
            if ((r_state == WAIT) && (r_wait_cnt != '1)) begin
                r_wait_cnt <= r_wait_cnt + 32'd1;
            end
        end
    end

    assign ihit_count = r_ihit_cnt;
    assign dhit_count = r_dhit_cnt;
    assign wait_count = r_wait_cnt;
`else
    assign ihit_count = '0;
    assign dhit_count = '0;
    assign wait_count = '0;
`endif

endmodule

`default_nettype wire
